// File: rtl/mips_multicycle_ctrl_if.sv
// Control-unit bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
// Carries the IR opcode and memory handshake in, and every datapath enable and mux select out.
interface mips_multicycle_ctrl_if #(
   parameter int OPCODE_W = 6
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                pc_write;
   logic                pc_write_cond;
   logic                pc_write_ncond;
   logic                iord;
   logic                mem_read;
   logic                mem_write;
   logic                ir_write;
   logic                mem_to_reg;
   logic                reg_dst;
   logic                reg_write;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          alu_op;
   logic [1:0]          pc_source;
   logic                illegal;
   logic                halted;
   logic [3:0]          state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_write_ncond, iord, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
             alu_op, pc_source, illegal, halted, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_write_ncond, iord, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
             alu_op, pc_source, illegal, halted, state
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready handshake, optional wait timeout and opcode trap.
// Define MIPS_MC_PERF_EN to add the cycle_count / instr_count performance counters.
module mips_multicycle_ctrl #(
   parameter int OPCODE_W    = 6,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input logic                    clk,
   input logic                    reset,
   mips_multicycle_ctrl_if.master bus
`ifdef MIPS_MC_PERF_EN
   ,
   output logic [CNT_W-1:0]       cycle_count,
   output logic [CNT_W-1:0]       instr_count
`endif
);

   if (OPCODE_W < 6) begin : g_bad_opcode_w
      $error("OPCODE_W must be at least 6");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be positive");
   end

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_RTEX   = 4'd7,
      S_RTWB   = 4'd8,
      S_BEQ    = 4'd9,
      S_BNE    = 4'd10,
      S_JUMP   = 4'd11,
      S_ADDIEX = 4'd12,
      S_ADDIWB = 4'd13,
      S_HALT   = 4'd14,
      S_BAD    = 4'd15
   } state_t;

   typedef enum logic [2:0] {
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_BAD
   } op_t;

   // fetch/decode mark the states whose outputs are further qualified by live inputs.
   typedef struct packed {
      logic       fetch;
      logic       decode;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_write_ncond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       halted;
   } ctrl_t;

   localparam int WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int WAIT_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

   state_t            st;
   state_t            nxt;
   ctrl_t             ctrl;
   op_t               op;
   logic              upper_zero;
   logic              waiting;
   logic              timeout;
   logic [WAIT_W-1:0] wait_cnt;

   function automatic ctrl_t moore_outputs(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
         S_DECODE: begin c.decode = 1'b1; c.alu_src_b = 2'b11; end
         S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
         S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
         S_RTEX:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         S_RTWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         S_BEQ:    begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write_cond = 1'b1;
         end
         S_BNE:    begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write_ncond = 1'b1;
         end
         S_JUMP:   begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
         S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_ADDIWB: begin c.reg_write = 1'b1; end
         S_HALT:   begin c.halted = 1'b1; end
         default:  ;
      endcase
      return c;
   endfunction

   assign upper_zero = ((bus.opcode >> 6) == '0);

   // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      op = OP_BAD;
      if (upper_zero) begin
         case (bus.opcode[5:0])
            6'b000000: op = OP_RTYPE;
            6'b100011: op = OP_LW;
            6'b101011: op = OP_SW;
            6'b000100: op = OP_BEQ;
            6'b000101: op = OP_BNE;
            6'b000010: op = OP_J;
            6'b001000: op = OP_ADDI;
            default:   op = OP_BAD;
         endcase
      end
   end

   assign waiting = ((st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR)) && !bus.mem_ready;
   assign timeout = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == WAIT_W'(WAIT_LAST));

   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:   nxt = S_FETCH;
         S_FETCH:  if (bus.mem_ready) nxt = S_DECODE; else if (timeout) nxt = S_HALT;
         S_DECODE: begin
            case (op)
               OP_RTYPE:      nxt = S_RTEX;
               OP_LW, OP_SW:  nxt = S_MEMADR;
               OP_BEQ:        nxt = S_BEQ;
               OP_BNE:        nxt = S_BNE;
               OP_J:          nxt = S_JUMP;
               OP_ADDI:       nxt = S_ADDIEX;
               default:       nxt = S_FETCH;
            endcase
         end
         S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (bus.mem_ready) nxt = S_MEMWB; else if (timeout) nxt = S_HALT;
         S_MEMWR:  if (bus.mem_ready) nxt = S_FETCH; else if (timeout) nxt = S_HALT;
         S_RTEX:   nxt = S_RTWB;
         S_ADDIEX: nxt = S_ADDIWB;
         S_MEMWB, S_RTWB, S_BEQ, S_BNE, S_JUMP, S_ADDIWB: nxt = S_FETCH;
         S_HALT:   nxt = S_HALT;
         default:  nxt = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state so they change with the state, glitch-free.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st       <= S_IDLE;
         ctrl     <= '0;
         wait_cnt <= '0;
      end else begin
         st       <= nxt;
         ctrl     <= moore_outputs(nxt);
         wait_cnt <= (waiting && !timeout) ? wait_cnt + WAIT_W'(1) : '0;
      end
   end

   assign bus.pc_write       = ctrl.pc_write | (ctrl.fetch & bus.mem_ready);
   assign bus.ir_write       = ctrl.fetch & bus.mem_ready;
   assign bus.illegal        = ctrl.decode & (op == OP_BAD);
   assign bus.pc_write_cond  = ctrl.pc_write_cond;
   assign bus.pc_write_ncond = ctrl.pc_write_ncond;
   assign bus.iord           = ctrl.iord;
   assign bus.mem_read       = ctrl.mem_read;
   assign bus.mem_write      = ctrl.mem_write;
   assign bus.mem_to_reg     = ctrl.mem_to_reg;
   assign bus.reg_dst        = ctrl.reg_dst;
   assign bus.reg_write      = ctrl.reg_write;
   assign bus.alu_src_a      = ctrl.alu_src_a;
   assign bus.alu_src_b      = ctrl.alu_src_b;
   assign bus.alu_op         = ctrl.alu_op;
   assign bus.pc_source      = ctrl.pc_source;
   assign bus.halted         = ctrl.halted;
   assign bus.state          = st;

`ifdef MIPS_MC_PERF_EN
   logic instr_done;

   // Illegal-opcode returns come from DECODE and are deliberately not counted.
   assign instr_done = (nxt == S_FETCH) &&
                       ((st == S_MEMWB) || (st == S_MEMWR) || (st == S_RTWB) || (st == S_BEQ) ||
                        (st == S_BNE) || (st == S_JUMP) || (st == S_ADDIWB));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         if ((st != S_IDLE) && (st != S_HALT)) cycle_count <= cycle_count + CNT_W'(1);
         if (instr_done) instr_count <= instr_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-level model expands each opcode into
// its expected per-cycle state/output trace and compares two DUTs (no timeout, MEM_TIMEOUT=3).
module tb_mips_multicycle_ctrl;

   typedef struct {
      int         st;
      bit         rdy;
      logic [5:0] opc;
   } step_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = '0;
   logic       mem_ready = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         n_steps = 0;
   int         n_legal = 0;
   int         n_instr = 0;
   bit         chk1 = 1'b1;
   step_t      q[$];
   logic [5:0] legal_ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000101, 6'b000010, 6'b001000};

   always #5 clk = ~clk;

   mips_multicycle_ctrl_if #(.OPCODE_W(6)) b0 ();
   mips_multicycle_ctrl_if #(.OPCODE_W(6)) b1 ();

   assign b0.opcode    = opcode;
   assign b1.opcode    = opcode;
   assign b0.mem_ready = mem_ready;
   assign b1.mem_ready = mem_ready;

`ifdef MIPS_MC_PERF_EN
   logic [31:0] cyc0, ins0;
   logic [3:0]  cyc1, ins1;
`endif

   mips_multicycle_ctrl #(.OPCODE_W(6), .MEM_TIMEOUT(0), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .bus(b0)
`ifdef MIPS_MC_PERF_EN
      , .cycle_count(cyc0), .instr_count(ins0)
`endif
   );

   mips_multicycle_ctrl #(.OPCODE_W(6), .MEM_TIMEOUT(3), .CNT_W(4)) dut_to (
      .clk(clk), .reset(reset), .bus(b1)
`ifdef MIPS_MC_PERF_EN
      , .cycle_count(cyc1), .instr_count(ins1)
`endif
   );

   logic [22:0] obs0, obs1;
   assign obs0 = {b0.state, b0.pc_write, b0.pc_write_cond, b0.pc_write_ncond, b0.iord, b0.mem_read,
                  b0.mem_write, b0.ir_write, b0.mem_to_reg, b0.reg_dst, b0.reg_write, b0.alu_src_a,
                  b0.alu_src_b, b0.alu_op, b0.pc_source, b0.illegal, b0.halted};
   assign obs1 = {b1.state, b1.pc_write, b1.pc_write_cond, b1.pc_write_ncond, b1.iord, b1.mem_read,
                  b1.mem_write, b1.ir_write, b1.mem_to_reg, b1.reg_dst, b1.reg_write, b1.alu_src_a,
                  b1.alu_src_b, b1.alu_op, b1.pc_source, b1.illegal, b1.halted};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] opc);
      return opc inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000};
   endfunction

   // Expected datapath controls for a cycle, straight from the per-state output table.
   function automatic logic [22:0] exp_obs(input int st, input bit rdy, input logic [5:0] opc);
      logic       pw = 0, pwc = 0, pwn = 0, iord = 0, mr = 0, mw = 0, irw = 0;
      logic       m2r = 0, rd = 0, rw = 0, asa = 0, ill = 0, hlt = 0;
      logic [1:0] asb = 0, aop = 0, psrc = 0;
      case (st)
         1:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
         2:  begin asb = 2'b11; ill = !is_legal(opc); end
         3:  begin asa = 1; asb = 2'b10; end
         4:  begin mr = 1; iord = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mw = 1; iord = 1; end
         7:  begin asa = 1; aop = 2'b10; end
         8:  begin rw = 1; rd = 1; end
         9:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pwc = 1; end
         10: begin asa = 1; aop = 2'b01; psrc = 2'b01; pwn = 1; end
         11: begin psrc = 2'b10; pw = 1; end
         12: begin asa = 1; asb = 2'b10; end
         13: begin rw = 1; end
         14: begin hlt = 1; end
         default: ;
      endcase
      return {4'(st), pw, pwc, pwn, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill, hlt};
   endfunction

   function automatic bit rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expand one instruction into its cycle trace: wf FETCH waits, wm memory-phase waits.
   task automatic gen_instr(input logic [5:0] opc, input int wf, input int wm);
      repeat (wf) q.push_back('{1, 1'b0, opc});
      q.push_back('{1, 1'b1, opc});
      q.push_back('{2, rnd_bit(), opc});
      case (opc)
         6'b100011: begin
            q.push_back('{3, rnd_bit(), opc});
            repeat (wm) q.push_back('{4, 1'b0, opc});
            q.push_back('{4, 1'b1, opc});
            q.push_back('{5, rnd_bit(), opc});
         end
         6'b101011: begin
            q.push_back('{3, rnd_bit(), opc});
            repeat (wm) q.push_back('{6, 1'b0, opc});
            q.push_back('{6, 1'b1, opc});
         end
         6'b000000: begin q.push_back('{7, rnd_bit(), opc}); q.push_back('{8, rnd_bit(), opc}); end
         6'b000100: q.push_back('{9, rnd_bit(), opc});
         6'b000101: q.push_back('{10, rnd_bit(), opc});
         6'b000010: q.push_back('{11, rnd_bit(), opc});
         6'b001000: begin q.push_back('{12, rnd_bit(), opc}); q.push_back('{13, rnd_bit(), opc}); end
         default: ;
      endcase
      if (is_legal(opc)) n_legal++;
   endtask

   task automatic run_instr(input logic [5:0] opc, input int wf, input int wm);
      step_t s;
      int    cyc = 0;
      gen_instr(opc, wf, wm);
      while (q.size() > 0) begin
         s = q.pop_front();
         @(posedge clk);
         #1;
         opcode    = s.opc;
         mem_ready = s.rdy;
         #1;
         check($sformatf("i%0d_c%0d_op%b", n_instr, cyc, s.opc), 32'(obs0), 32'(exp_obs(s.st, s.rdy, s.opc)));
         if (chk1)
            check($sformatf("to_i%0d_c%0d_op%b", n_instr, cyc, s.opc), 32'(obs1),
                  32'(exp_obs(s.st, s.rdy, s.opc)));
         cyc++;
         n_steps++;
      end
      n_instr++;
   endtask

   initial begin
      logic [5:0] opc;
      int         k;

      // Reset held low for three cycles: IDLE with every output low.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         check($sformatf("rst_c%0d", i), 32'(obs0), 32'(exp_obs(0, 1'b0, 6'd0)));
         check($sformatf("rst_to_c%0d", i), 32'(obs1), 32'(exp_obs(0, 1'b0, 6'd0)));
      end
      @(negedge clk);
      reset = 1'b1;
      #2;
      check("idle_after_release", 32'(obs0), 32'(exp_obs(0, 1'b0, 6'd0)));

      // Directed: lw, bne, illegal opcode, all with memory ready.
      run_instr(6'b100011, 0, 0);
      run_instr(6'b000101, 0, 0);
      run_instr(6'b111111, 0, 0);

      // Random mix; waits stay below the timeout so both DUTs must agree.
      for (int i = 0; i < 60; i++) begin
         k = int'($urandom_range(0, 7));
         if (k < 7) opc = legal_ops[k];
         else begin
            opc = 6'($urandom_range(0, 63));
            while (is_legal(opc)) opc = 6'($urandom_range(0, 63));
         end
         run_instr(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      // One more edge so the final instruction's retirement is visible.
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      #1;
      check("fetch_after_random", 32'(obs0), 32'(exp_obs(1, 1'b0, opcode)));
`ifdef MIPS_MC_PERF_EN
      check("cycle_count", cyc0, 32'(n_steps));
      check("instr_count", ins0, 32'(n_legal));
      check("cycle_count_w4", 32'(cyc1), 32'(n_steps % 16));
      check("instr_count_w4", 32'(ins1), 32'(n_legal % 16));
`endif

      // sw with four MEMWR wait cycles on the no-timeout DUT only.
      chk1 = 1'b0;
      run_instr(6'b101011, 0, 4);

      // Timeout: memory never ready in FETCH.
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("async_reset", 32'(obs0), 32'(exp_obs(0, 1'b0, 6'd0)));
      check("async_reset_to", 32'(obs1), 32'(exp_obs(0, 1'b0, 6'd0)));
      mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #2;
         check($sformatf("stuck_c%0d", i), 32'(obs0), 32'(exp_obs(1, 1'b0, opcode)));
         check($sformatf("to_stuck_c%0d", i), 32'(obs1),
               32'(exp_obs((i <= 3) ? 1 : 14, 1'b0, opcode)));
      end
      #1;
      reset = 1'b0;
      #1;
      check("halt_reset", 32'(obs1), 32'(exp_obs(0, 1'b0, 6'd0)));
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      @(posedge clk);
      #2;
      check("halt_restart", 32'(obs1), 32'(exp_obs(1, 1'b1, opcode)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
